// File: rtl/parking_gate_controller.sv
// parking_gate_controller: debounces four gate sensors, arbitrates entry/exit requests,
// tracks per-class occupancy and times the barrier.
module parking_gate_controller #(
    parameter int DEBOUNCE_CYCLES  = 4,
    parameter int CAR_CAPACITY     = 20,
    parameter int BIKE_CAPACITY    = 40,
    parameter int GATE_OPEN_CYCLES = 8,
    parameter int CNT_W            = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             car_in_sensor,
    input  logic             bike_in_sensor,
    input  logic             car_out_sensor,
    input  logic             bike_out_sensor,
    output logic             car_entry,
    output logic             bike_entry,
    output logic             car_exit,
    output logic             bike_exit,
    output logic             reject,
    output logic             gate_open,
    output logic             car_full,
    output logic             bike_full,
    output logic [CNT_W-1:0] cars_present,
    output logic [CNT_W-1:0] bikes_present
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW = $clog2(GATE_OPEN_CYCLES + 1);

    typedef enum logic {IDLE, OPEN} state_t;

    // Bit order doubles as priority: lowest index wins.
    logic [3:0] raw, s1, s2, lvl, lvl_d, pend, svc;
    logic [TW-1:0] timer;
    logic [CNT_W-1:0] cars_nx, bikes_nx;
    logic g_cx, g_bx, g_ce, g_be, rej;
    state_t state;

    assign raw = {bike_in_sensor, car_in_sensor, bike_out_sensor, car_out_sensor};

    for (genvar i = 0; i < 4; i++) begin : g_db
        logic [DW-1:0] cnt;
        logic lv;
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                cnt <= '0;
                lv  <= 1'b0;
            end else if (s2[i] == lv) begin
                cnt <= '0;
            end else if (cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                cnt <= '0;
                lv  <= s2[i];
            end else begin
                cnt <= cnt + DW'(1);
            end
        end
        assign lvl[i] = lv;
    end

    always_comb begin
        svc      = pend & (~pend + 4'd1);
        g_cx     = svc[0] && cars_present != '0;
        g_bx     = svc[1] && bikes_present != '0;
        g_ce     = svc[2] && cars_present != CNT_W'(CAR_CAPACITY);
        g_be     = svc[3] && bikes_present != CNT_W'(BIKE_CAPACITY);
        rej      = (|svc) && !(g_cx || g_bx || g_ce || g_be);
        cars_nx  = g_ce ? cars_present + CNT_W'(1) : g_cx ? cars_present - CNT_W'(1) : cars_present;
        bikes_nx = g_be ? bikes_present + CNT_W'(1) : g_bx ? bikes_present - CNT_W'(1) : bikes_present;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1            <= '0;
            s2            <= '0;
            lvl_d         <= '0;
            pend          <= '0;
            car_entry     <= 1'b0;
            bike_entry    <= 1'b0;
            car_exit      <= 1'b0;
            bike_exit     <= 1'b0;
            reject        <= 1'b0;
            cars_present  <= '0;
            bikes_present <= '0;
            car_full      <= 1'b0;
            bike_full     <= 1'b0;
            state         <= IDLE;
            gate_open     <= 1'b0;
            timer         <= '0;
        end else begin
            s1            <= raw;
            s2            <= s1;
            lvl_d         <= lvl;
            pend          <= (pend & ~svc) | (lvl & ~lvl_d);
            car_exit      <= g_cx;
            bike_exit     <= g_bx;
            car_entry     <= g_ce;
            bike_entry    <= g_be;
            reject        <= rej;
            cars_present  <= cars_nx;
            bikes_present <= bikes_nx;
            car_full      <= cars_nx == CNT_W'(CAR_CAPACITY);
            bike_full     <= bikes_nx == CNT_W'(BIKE_CAPACITY);
            // Gate reacts to the registered grant, so it rises one cycle after the pulse.
            if (car_entry || bike_entry || car_exit || bike_exit) begin
                state     <= OPEN;
                gate_open <= 1'b1;
                timer     <= TW'(GATE_OPEN_CYCLES);
            end else if (state == OPEN) begin
                timer <= timer - TW'(1);
                if (timer == TW'(1)) begin
                    state     <= IDLE;
                    gate_open <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_parking_gate_controller.sv
// tb_parking_gate_controller: table-driven requests with a pulse scoreboard plus hand-written
// collision, capacity and reset sequences.
module tb_parking_gate_controller;
    localparam int K_CE = 0, K_BE = 1, K_CX = 2, K_BX = 3, K_REJ = 4, K_NONE = 7;
    localparam int LAT = 8;

    typedef struct {
        int kind;
        int cars;
        int bikes;
        int cyc;
    } exp_t;

    typedef struct {
        logic [3:0] m;
        int hold;
        int kind;
        int cars;
        int bikes;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic car_in_sensor = 1'b0, bike_in_sensor = 1'b0, car_out_sensor = 1'b0, bike_out_sensor = 1'b0;
    logic car_entry, bike_entry, car_exit, bike_exit, reject, gate_open, car_full, bike_full;
    logic [7:0] cars_present, bikes_present;

    int cyc = 0;
    int total = 0;
    int passed = 0;
    int gate_hi = 0;
    int gate_rise_cyc = -1;
    int last_grant_cyc = -1;
    logic gate_prev = 1'b0;
    exp_t q[$];

    parking_gate_controller dut (
        .clk(clk), .rst(rst),
        .car_in_sensor(car_in_sensor), .bike_in_sensor(bike_in_sensor),
        .car_out_sensor(car_out_sensor), .bike_out_sensor(bike_out_sensor),
        .car_entry(car_entry), .bike_entry(bike_entry), .car_exit(car_exit), .bike_exit(bike_exit),
        .reject(reject), .gate_open(gate_open), .car_full(car_full), .bike_full(bike_full),
        .cars_present(cars_present), .bikes_present(bikes_present)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Scoreboard: every observed pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        automatic int k;
        automatic exp_t e;
        if (car_entry || bike_entry || car_exit || bike_exit || reject) begin
            k = car_entry ? K_CE : bike_entry ? K_BE : car_exit ? K_CX : bike_exit ? K_BX : K_REJ;
            if (!reject) last_grant_cyc = cyc;
            chk("onehot", $countones({car_entry, bike_entry, car_exit, bike_exit, reject}), 1);
            if (q.size() == 0) begin
                chk("unexpected_pulse", k, K_NONE);
            end else begin
                e = q.pop_front();
                chk("kind", k, e.kind);
                chk("cars", int'(cars_present), e.cars);
                chk("bikes", int'(bikes_present), e.bikes);
                chk("latency", cyc, e.cyc);
            end
        end
        if (gate_open) gate_hi++;
        if (gate_open && !gate_prev) gate_rise_cyc = cyc;
        gate_prev = gate_open;
    end

    task automatic set_sensors(input logic [3:0] m);
        {bike_out_sensor, car_out_sensor, bike_in_sensor, car_in_sensor} = m;
    endtask

    task automatic start(input logic [3:0] m, output int e);
        @(posedge clk);
        #1;
        set_sensors(m);
        e = cyc;
    endtask

    task automatic finish(input int hold);
        repeat (hold) @(posedge clk);
        #1;
        set_sensors(4'b0000);
        repeat (20) @(posedge clk);
        #1;
        chk("drain", q.size(), 0);
    endtask

    task automatic push(input int kind, input int cars, input int bikes, input int at);
        exp_t x;
        x.kind = kind;
        x.cars = cars;
        x.bikes = bikes;
        x.cyc = at;
        q.push_back(x);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        // mask bits: [0] car_in, [1] bike_in, [2] car_out, [3] bike_out
        automatic vec_t tbl[9] = '{
            '{4'b0001, 10, K_CE,   1, 0},
            '{4'b0010,  3, K_NONE, 1, 0},
            '{4'b0010, 10, K_BE,   1, 1},
            '{4'b0100, 10, K_CX,   0, 1},
            '{4'b0100, 10, K_REJ,  0, 1},
            '{4'b1000, 10, K_BX,   0, 0},
            '{4'b1000, 10, K_REJ,  0, 0},
            '{4'b0010,  4, K_BE,   0, 1},
            '{4'b0001, 10, K_CE,   1, 1}
        };
        int e;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("rst_gate", gate_open, 0);
        chk("rst_cars", cars_present, 0);
        chk("rst_bikes", bikes_present, 0);
        chk("rst_full", {car_full, bike_full}, 0);
        chk("rst_gate_hi", gate_hi, 0);

        for (int i = 0; i < 9; i++) begin
            gate_hi = 0;
            start(tbl[i].m, e);
            if (tbl[i].kind != K_NONE) push(tbl[i].kind, tbl[i].cars, tbl[i].bikes, e + LAT);
            finish(tbl[i].hold);
            chk($sformatf("row%0d_cars", i), cars_present, tbl[i].cars);
            chk($sformatf("row%0d_bikes", i), bikes_present, tbl[i].bikes);
            if (i == 0) begin
                chk("gate_cycles", gate_hi, 8);
                chk("gate_rise", gate_rise_cyc, last_grant_cyc + 1);
            end
            if (tbl[i].kind == K_REJ || tbl[i].kind == K_NONE) chk($sformatf("row%0d_gate", i), gate_hi, 0);
        end

        // All four sensors together, one car and one bike present.
        start(4'b1111, e);
        push(K_CX, 0, 1, e + LAT);
        push(K_BX, 0, 0, e + LAT + 1);
        push(K_CE, 1, 0, e + LAT + 2);
        push(K_BE, 1, 1, e + LAT + 3);
        finish(10);
        chk("coll_cars", cars_present, 1);
        chk("coll_bikes", bikes_present, 1);

        // Asynchronous reset while the barrier is up.
        start(4'b0001, e);
        push(K_CE, 2, 1, e + LAT);
        repeat (10) @(posedge clk);
        #1;
        chk("gate_up_before_rst", gate_open, 1);
        #1;
        rst = 1'b0;
        #1;
        chk("async_gate", gate_open, 0);
        chk("async_cars", cars_present, 0);
        chk("async_bikes", bikes_present, 0);
        set_sensors(4'b0000);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        chk("rst_drain", q.size(), 0);

        for (int i = 0; i < 20; i++) begin
            start(4'b0001, e);
            push(K_CE, i + 1, 0, e + LAT);
            finish(6);
        end
        chk("full_at_cap", car_full, 1);
        gate_hi = 0;
        start(4'b0001, e);
        push(K_REJ, 20, 0, e + LAT);
        finish(6);
        chk("cap_cars", cars_present, 20);
        chk("cap_full", car_full, 1);
        chk("cap_gate", gate_hi, 0);

        start(4'b0100, e);
        push(K_CX, 19, 0, e + LAT);
        finish(6);
        chk("unfull", car_full, 0);
        chk("bike_full", bike_full, 0);

        do_reset();
        repeat (5) @(posedge clk);
        #1;
        chk("final_cars", cars_present, 0);
        chk("final_q", q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got %0d checks, expected completion", total);
        $fatal(1, "timeout");
    end
endmodule
